sram_dual_port_arbiter: RTL
===========================

# sram_dual_port_arbiter

Single-clock controller that shares the RW port (port 0) of the 1RW+1R OpenRAM SRAM macro between two read/write requesters, A and B, using round-robin arbitration, and gives a read-only requester R direct access to the R port (port 1). It registers every macro input, returns read data with fixed latency, and stalls R whenever R would read the address being written on port 0 in the same cycle. The block sits between the SRAM macro and the fabric clients and drives both macro clocks from one clock.

## Interface
- DATA_WIDTH, 8, macro word width
- ADDR_WIDTH, 10, macro address width (RAM_DEPTH = 1<<ADDR_WIDTH)

- clk0  in  1  sole clock; also forwarded to macro clk0 and clk1
- rst_n  in  1  reset, asynchronous, active-low
- a_valid / b_valid  in  1  request valid, requester A / B
- a_ready / b_ready  out  1  request accepted this cycle (combinational grant)
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata / b_rdata  out  DATA_WIDTH  read data
- r_valid  in  1  read request, requester R
- r_ready  out  1  R request accepted
- r_addr  in  ADDR_WIDTH  R read address
- r_rvalid  out  1  R read data valid
- r_rdata  out  DATA_WIDTH  R read data
- sram_csb0, sram_web0  out  1  macro port-0 chip select / write enable (active-low)
- sram_addr0  out  ADDR_WIDTH, sram_din0  out  DATA_WIDTH  macro port-0 address / data
- sram_dout0  in  DATA_WIDTH  macro port-0 read data
- sram_csb1  out  1, sram_addr1  out  ADDR_WIDTH  macro port-1 select / address
- sram_dout1  in  DATA_WIDTH  macro port-1 read data

## Operation
- Port 0 arbitration: at most one grant per cycle. Only one of A/B valid → that one granted. Both valid → grant to requester named by priority pointer `prio`; after any grant, `prio` points to the other requester. Reset: `prio` = A.
- Accepted port-0 request (valid && ready at edge E): at E, sram_csb0=0, sram_web0=~we, sram_addr0, sram_din0 registered. No accept at E → sram_csb0=1, web0=1, addr0/din0 hold.
- R port: r_ready = r_valid && !hazard, where hazard = port-0 grant this cycle is a write to r_addr. Accepted R at E → sram_csb1=0, sram_addr1 registered; else sram_csb1=1, addr1 holds.
- Read return: 2-stage tag pipeline {valid, owner∈{A,B}} for port 0, 2-stage valid for port 1. At E+2 the macro dout is captured into the owner's rdata and its rvalid is high for the cycle after E+2.
- Writes produce no response. Responses have no backpressure; clients always accept.
- Read-after-write through port 0 or port 1, issued on a later cycle than the write, returns the new data.

## Timing
- Throughput: one port-0 op and one port-1 read per cycle.
- Read latency: rvalid high in cycle E+2 (second rising edge after the accept edge E).
- Reset values: sram_csb0=1, sram_web0=1, sram_csb1=1, sram_addr0/addr1/din0=0, all rvalid=0, all rdata=0, tag pipeline cleared, prio=A. a_ready/b_ready/r_ready are 0 while rst_n=0.
- Reset asserted mid-operation: in-flight tags are discarded, and no rvalid is produced for reads accepted before reset.
- Boundaries: addresses 0 and RAM_DEPTH-1 are legal. Same-address port-0 read and port-1 read in one cycle is allowed. Hazard stalls R for exactly as long as the conflicting write grant persists.

## Structure
- Package sram_ctrl_pkg: owner_e {OWN_A, OWN_B}, port-0 request struct {we, addr, wdata}, localparam READ_LATENCY = 2.
- Sub-module rr_arbiter2: two-requester round-robin arbiter holding `prio`, outputs one-hot grant.

## Test plan
- A-only write 0x3FF←0xA5, then A read 0x3FF → a_rvalid in E+2, a_rdata=0xA5, b_rvalid stays 0.
- A and B both valid for 4 cycles → grants A,B,A,B. Reads of addresses 1 and 2 (preloaded 0x11 and 0x22) return to the correct owners.
- A writes 0x010←0x5A while R reads 0x010 in the same cycle → r_ready=0 that cycle. R accepted next cycle → r_rdata=0x5A.
- R reads 0x020 while B reads 0x020 in the same cycle → both accepted, both return the same data in E+2.
- Back-to-back B reads on consecutive cycles to 0..7 → b_rvalid high 8 consecutive cycles, data in order.
- Reset asserted one cycle after A read accept → no a_rvalid, all outputs at reset values. After release, prio=A.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the dual-port SRAM controller.
package sram_ctrl_pkg;

  // Which port-0 requester a read response belongs to.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // Default macro geometry (8-bit words, 1024 entries).
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_ADDR_WIDTH = 10;

  // Edges from request accept to response capture.
  localparam int READ_LATENCY = 2;

  // Port-0 request as presented by a read/write client.
  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } p0_req_t;

endpackage

// File: rtl/sram_dual_port_arbiter_if.sv
// Client and macro-side signals of the dual-port SRAM controller.
// The slave modport is the controller's view; master is the view of the
// clients plus the macro.
interface sram_dual_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);

  // Requester A (read/write, port 0)
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  // Requester B (read/write, port 0)
  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  // Requester R (read-only, port 1)
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Macro port 0 (RW) and port 1 (R)
  logic                  sram_csb0;
  logic                  sram_web0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0;
  logic [DATA_WIDTH-1:0] sram_dout0;
  logic                  sram_csb1;
  logic [ADDR_WIDTH-1:0] sram_addr1;
  logic [DATA_WIDTH-1:0] sram_dout1;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    input  r_valid, r_addr,
    output r_ready, r_rvalid, r_rdata,
    output sram_csb0, sram_web0, sram_addr0, sram_din0,
    input  sram_dout0,
    output sram_csb1, sram_addr1,
    input  sram_dout1
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    output r_valid, r_addr,
    input  r_ready, r_rvalid, r_rdata,
    input  sram_csb0, sram_web0, sram_addr0, sram_din0,
    output sram_dout0,
    input  sram_csb1, sram_addr1,
    output sram_dout1
  );

endinterface

// File: rtl/sram_dual_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. Grant is combinational and one-hot
// (or zero); the priority pointer flips to the other requester after
// every grant, so a lone requester never loses its turn permanently.
module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic       clk0,
  input  logic       rst_n,
  input  logic [1:0] req,    // bit 0 = A, bit 1 = B
  output logic [1:0] grant   // bit 0 = A, bit 1 = B
);

  owner_e prio_reg;

  // Pick the single requester, or the prioritised one on contention;
  // nothing is granted while reset is asserted.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (prio_reg == OWN_A) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Hand priority to whoever was not just served.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= OWN_A;
    end else if (grant[0]) begin
      prio_reg <= OWN_B;
    end else if (grant[1]) begin
      prio_reg <= OWN_A;
    end
  end

endmodule

// File: rtl/sram_dual_port_arbiter.sv
// Controller for a 1RW+1R SRAM macro: A and B share the RW port through
// a round-robin arbiter, R reads through the R port. All macro inputs are
// registered; read data returns a fixed two edges after acceptance.
module sram_dual_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input logic                     clk0,
  input logic                     rst_n,
  sram_dual_port_arbiter_if.slave bus
);

  logic [1:0]            grant;
  logic                  p0_accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  hazard;
  logic                  r_accept;

  logic                  csb0_reg;
  logic                  web0_reg;
  logic [ADDR_WIDTH-1:0] addr0_reg;
  logic [DATA_WIDTH-1:0] din0_reg;
  logic                  csb1_reg;
  logic [ADDR_WIDTH-1:0] addr1_reg;

  logic [READ_LATENCY-1:0] p0_tag_valid_reg;
  owner_e                  p0_tag_owner_reg [READ_LATENCY];
  logic [READ_LATENCY-1:0] p1_tag_valid_reg;

  logic                  r_rvalid_reg;
  logic [DATA_WIDTH-1:0] r_rdata_reg;
  logic [1:0]            rvalid_vec;
  logic [DATA_WIDTH-1:0] rdata_vec [2];

  rr_arbiter2 u_arb (
    .clk0  (clk0),
    .rst_n (rst_n),
    .req   ({bus.b_valid, bus.a_valid}),
    .grant (grant)
  );

  assign p0_accept   = |grant;
  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];

  // Route the winning requester's command onto the port-0 path.
  always_comb begin
    sel_we    = bus.a_we;
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    if (grant[1]) begin
      sel_we    = bus.b_we;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end
  end

  // R must not read a word that port 0 writes on the same edge: the macro
  // would return stale data, so R waits until the write grant is gone.
  assign hazard      = p0_accept && sel_we && (sel_addr == bus.r_addr);
  assign r_accept    = rst_n && bus.r_valid && !hazard;
  assign bus.r_ready = r_accept;

  // Port-0 macro inputs: select on accept, otherwise deselect and hold.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      csb0_reg  <= 1'b1;
      web0_reg  <= 1'b1;
      addr0_reg <= '0;
      din0_reg  <= '0;
    end else if (p0_accept) begin
      csb0_reg  <= 1'b0;
      web0_reg  <= ~sel_we;
      addr0_reg <= sel_addr;
      din0_reg  <= sel_wdata;
    end else begin
      csb0_reg <= 1'b1;
      web0_reg <= 1'b1;
    end
  end

  // Port-1 macro inputs: select on R accept, otherwise deselect and hold.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      csb1_reg  <= 1'b1;
      addr1_reg <= '0;
    end else if (r_accept) begin
      csb1_reg  <= 1'b0;
      addr1_reg <= bus.r_addr;
    end else begin
      csb1_reg <= 1'b1;
    end
  end

  assign bus.sram_csb0  = csb0_reg;
  assign bus.sram_web0  = web0_reg;
  assign bus.sram_addr0 = addr0_reg;
  assign bus.sram_din0  = din0_reg;
  assign bus.sram_csb1  = csb1_reg;
  assign bus.sram_addr1 = addr1_reg;

  // Read tags follow the macro access; reset drops anything in flight.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      p0_tag_valid_reg <= '0;
      p1_tag_valid_reg <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        p0_tag_owner_reg[i] <= OWN_A;
      end
    end else begin
      p0_tag_valid_reg[0] <= p0_accept && !sel_we;
      p0_tag_owner_reg[0] <= grant[1] ? OWN_B : OWN_A;
      p1_tag_valid_reg[0] <= r_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        p0_tag_valid_reg[i] <= p0_tag_valid_reg[i-1];
        p0_tag_owner_reg[i] <= p0_tag_owner_reg[i-1];
        p1_tag_valid_reg[i] <= p1_tag_valid_reg[i-1];
      end
    end
  end

  // One response register per port-0 owner (0 = A, 1 = B).
  for (genvar gi = 0; gi < 2; gi++) begin : g_owner
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  hit;

    assign hit = p0_tag_valid_reg[READ_LATENCY-1] &&
                 ((p0_tag_owner_reg[READ_LATENCY-1] == OWN_B) == (gi == 1));

    // Capture port-0 data when the oldest tag belongs to this owner.
    always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= hit;
        if (hit) begin
          rdata_reg <= bus.sram_dout0;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign rdata_vec[gi]  = rdata_reg;
  end

  // Capture port-1 data for R when its oldest tag is valid.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid_reg <= 1'b0;
      r_rdata_reg  <= '0;
    end else begin
      r_rvalid_reg <= p1_tag_valid_reg[READ_LATENCY-1];
      if (p1_tag_valid_reg[READ_LATENCY-1]) begin
        r_rdata_reg <= bus.sram_dout1;
      end
    end
  end

  assign bus.a_rvalid = rvalid_vec[0];
  assign bus.a_rdata  = rdata_vec[0];
  assign bus.b_rvalid = rvalid_vec[1];
  assign bus.b_rdata  = rdata_vec[1];
  assign bus.r_rvalid = r_rvalid_reg;
  assign bus.r_rdata  = r_rdata_reg;

endmodule
